// File: rtl/vga_pixel_reader.sv
// VGA raster generator that requests one pixel per active position and realigns returned RGB with sync/blank.
// Latency: request to DAC output is LATENCY+1 cycles; no backpressure, upstream must answer every request.
module vga_pixel_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int LATENCY  = 2
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic [9:0] iRed,
    input  logic [9:0] iGreen,
    input  logic [9:0] iBlue,
    output logic       oRequest,
    output logic [9:0] oReqX,
    output logic [9:0] oReqY,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic       oHS,
    output logic       oVS,
    output logic       oBLANK_n,
    output logic       oFrameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEGIN   = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEGIN   = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
    } tuple_t;

    logic [9:0] h;
    logic [9:0] v;
    logic       run;
    logic       act;
    tuple_t     cur;
    tuple_t     tail;
    tuple_t     pipe [LATENCY+1];

    // run holds the counters at (0,0) for one cycle after reset release
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            h   <= '0;
            v   <= '0;
            run <= 1'b0;
        end else begin
            run <= 1'b1;
            if (run) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
            end
        end
    end

    always_comb begin
        act     = ({1'b0, h} < H_ACT_END) && ({1'b0, v} < V_ACT_END);
        cur     = '0;
        cur.act = act;
        cur.hs  = ({1'b0, h} >= HS_BEGIN) && ({1'b0, h} < HS_END);
        cur.vs  = ({1'b0, v} >= VS_BEGIN) && ({1'b0, v} < VS_END);
        cur.fs  = (h == 10'd0) && (v == 10'd0);
    end

    // pipe[0] launches with the request; pipe[LATENCY] lines up with returned data
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oRequest <= 1'b0;
            oReqX    <= '0;
            oReqY    <= '0;
            for (int k = 0; k <= LATENCY; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            if (run) begin
                oRequest <= act;
                oReqX    <= act ? h : 10'd0;
                oReqY    <= act ? v : 10'd0;
                pipe[0]  <= cur;
            end
            for (int k = 1; k <= LATENCY; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign tail = pipe[LATENCY];

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            oRed        <= '0;
            oGreen      <= '0;
            oBlue       <= '0;
            oHS         <= 1'b1;
            oVS         <= 1'b1;
            oBLANK_n    <= 1'b0;
            oFrameStart <= 1'b0;
        end else begin
            oRed        <= tail.act ? iRed   : 10'd0;
            oGreen      <= tail.act ? iGreen : 10'd0;
            oBlue       <= tail.act ? iBlue  : 10'd0;
            oHS         <= ~tail.hs;
            oVS         <= ~tail.vs;
            oBLANK_n    <= tail.act;
            oFrameStart <= tail.fs;
        end
    end

endmodule
